// File: rtl/carregador_operandos_if.sv
// Word stream into the operand loader and result stream out of it.
// master = neighbour side, slave = loader side.
interface carregador_operandos_if #(
    parameter int LARGURA = 16
);
    logic [LARGURA-1:0] dado_in;
    logic               dado_valido;
    logic               dado_pronto;
    logic [LARGURA-1:0] resultado_out;
    logic               resultado_valido;
    logic               resultado_aceito;

    modport master (
        output dado_in,
        output dado_valido,
        output resultado_aceito,
        input  dado_pronto,
        input  resultado_out,
        input  resultado_valido
    );

    modport slave (
        input  dado_in,
        input  dado_valido,
        input  resultado_aceito,
        output dado_pronto,
        output resultado_out,
        output resultado_valido
    );
endinterface

// File: rtl/carregador_operandos.sv
// Loads X, A, B, C serially, starts the polynomial core and returns
// its result, with a timeout that parks the block in ERRO.
module carregador_operandos #(
    parameter int LARGURA       = 16,
    parameter int INICIO_CICLOS = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                 ck,
    input  logic                 rst,
    carregador_operandos_if.slave bus,
    output logic [LARGURA-1:0]   X,
    output logic [LARGURA-1:0]   A,
    output logic [LARGURA-1:0]   B,
    output logic [LARGURA-1:0]   C,
    output logic                 inicio,
    input  logic                 LED,
    input  logic [LARGURA-1:0]   Resultado,
    output logic                 pronto,
    output logic                 ocupado,
    output logic                 erro
);

    localparam int CMAX = (TIMEOUT > INICIO_CICLOS) ?
                          TIMEOUT : INICIO_CICLOS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        CARGA,
        INICIA,
        ESPERA,
        CAPTURA,
        ENTREGA,
        ERRO
    } estado_t;

    estado_t            estado;
    estado_t            estado_n;
    logic [1:0]         idx;
    logic [1:0]         idx_n;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;

    logic [LARGURA-1:0] x_n;
    logic [LARGURA-1:0] a_n;
    logic [LARGURA-1:0] b_n;
    logic [LARGURA-1:0] c_n;
    logic [LARGURA-1:0] res_n;

    logic               inicio_n;
    logic               pronto_n;
    logic               valido_n;
    logic               dpronto_n;
    logic               ocupado_n;
    logic               erro_n;
    logic               transf;

    assign transf = bus.dado_valido & bus.dado_pronto;

    // Every output is computed here from the next state and
    // registered below, so the core sees glitch-free levels.
    always_comb begin
        estado_n  = estado;
        idx_n     = idx;
        cnt_n     = cnt;
        x_n       = X;
        a_n       = A;
        b_n       = B;
        c_n       = C;
        res_n     = bus.resultado_out;
        inicio_n  = 1'b0;
        pronto_n  = 1'b0;
        valido_n  = 1'b0;
        dpronto_n = 1'b0;
        erro_n    = 1'b0;

        unique case (estado)
            CARGA: begin
                dpronto_n = 1'b1;
                if (transf) begin
                    unique case (1'b1)
                        (idx == 2'd0): x_n = bus.dado_in;
                        (idx == 2'd1): a_n = bus.dado_in;
                        (idx == 2'd2): b_n = bus.dado_in;
                        (idx == 2'd3): c_n = bus.dado_in;
                        default: ;
                    endcase
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) begin
                        estado_n  = INICIA;
                        cnt_n     = '0;
                        dpronto_n = 1'b0;
                        inicio_n  = 1'b1;
                    end
                end
            end

            INICIA: begin
                if (cnt == CW'(INICIO_CICLOS - 1)) begin
                    estado_n = ESPERA;
                    cnt_n    = '0;
                end else begin
                    cnt_n    = cnt + 1'b1;
                    inicio_n = 1'b1;
                end
            end

            // LED is checked first so a late done still wins the race.
            ESPERA: begin
                if (LED) begin
                    estado_n = CAPTURA;
                    pronto_n = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    estado_n = ERRO;
                    erro_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            CAPTURA: begin
                res_n    = Resultado;
                valido_n = 1'b1;
                estado_n = ENTREGA;
            end

            ENTREGA: begin
                if (bus.resultado_aceito) begin
                    estado_n  = CARGA;
                    idx_n     = 2'd0;
                    dpronto_n = 1'b1;
                end else begin
                    valido_n = 1'b1;
                end
            end

            ERRO: begin
                erro_n = 1'b1;
            end

            default: begin
                estado_n  = CARGA;
                idx_n     = 2'd0;
                dpronto_n = 1'b1;
            end
        endcase

        ocupado_n = (estado_n != CARGA);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            estado               <= CARGA;
            idx                  <= 2'd0;
            cnt                  <= '0;
            X                    <= '0;
            A                    <= '0;
            B                    <= '0;
            C                    <= '0;
            bus.resultado_out    <= '0;
            inicio               <= 1'b0;
            pronto               <= 1'b0;
            bus.resultado_valido <= 1'b0;
            bus.dado_pronto      <= 1'b1;
            ocupado              <= 1'b0;
            erro                 <= 1'b0;
        end else begin
            estado               <= estado_n;
            idx                  <= idx_n;
            cnt                  <= cnt_n;
            X                    <= x_n;
            A                    <= a_n;
            B                    <= b_n;
            C                    <= c_n;
            bus.resultado_out    <= res_n;
            inicio               <= inicio_n;
            pronto               <= pronto_n;
            bus.resultado_valido <= valido_n;
            bus.dado_pronto      <= dpronto_n;
            ocupado              <= ocupado_n;
            erro                 <= erro_n;
        end
    end

endmodule

// File: tb/tb_carregador_operandos.sv
// Bench for carregador_operandos: directed and random runs against a
// simple polynomial core model and arithmetic expectations.
module tb_carregador_operandos;

    localparam int W  = 16;
    localparam int IC = 2;
    localparam int TO = 64;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    carregador_operandos_if #(.LARGURA(W)) bus ();

    logic [W-1:0] X, A, B, C, Resultado;
    logic         inicio, LED, pronto, ocupado, erro;

    carregador_operandos #(
        .LARGURA(W),
        .INICIO_CICLOS(IC),
        .TIMEOUT(TO)
    ) dut (
        .ck(ck),
        .rst(rst),
        .bus(bus),
        .X(X),
        .A(A),
        .B(B),
        .C(C),
        .inicio(inicio),
        .LED(LED),
        .Resultado(Resultado),
        .pronto(pronto),
        .ocupado(ocupado),
        .erro(erro)
    );

    int nvec = 0;
    int nerr = 0;

    function automatic logic [W-1:0] poly(input logic [W-1:0] x,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        longint r;
        r = longint'(a) * longint'(x) * longint'(x)
          + longint'(b) * longint'(x) + longint'(c);
        return r[W-1:0];
    endfunction

    // Core model: done flag some cycles after the start request.
    bit           auto_core = 1'b1;
    int           led_delay = 10;
    logic         core_led;
    logic [W-1:0] core_res;
    bit           armed;
    int           ccnt;
    logic         man_led = 1'b0;
    logic [W-1:0] man_res = '0;

    assign LED       = auto_core ? core_led : man_led;
    assign Resultado = auto_core ? core_res : man_res;

    always @(posedge ck) begin
        if (rst) begin
            core_led <= 1'b0;
            core_res <= '0;
            armed    <= 1'b0;
            ccnt     <= 0;
        end else if (pronto) begin
            core_led <= 1'b0;
            armed    <= 1'b0;
        end else if (inicio && !armed) begin
            armed <= 1'b1;
            ccnt  <= 1;
        end else if (armed && !core_led) begin
            ccnt <= ccnt + 1;
            if (ccnt >= led_delay) begin
                core_led <= 1'b1;
                core_res <= poly(X, A, B, C);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) tick();
        bus.dado_in     = w;
        bus.dado_valido = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.dado_pronto) ok = 1'b1;
            tick();
        end
        bus.dado_valido = 1'b0;
        if (!ok) chk("transfer_timeout", 32'(ok), 1);
    endtask

    task automatic check_loaded(input logic [W-1:0] x, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] c);
        chk("op_X", 32'(X), 32'(x));
        chk("op_A", 32'(A), 32'(a));
        chk("op_B", 32'(B), 32'(b));
        chk("op_C", 32'(C), 32'(c));
        chk("dado_pronto_after4", 32'(bus.dado_pronto), 0);
        chk("ocupado_after4", 32'(ocupado), 1);
    endtask

    task automatic pulso_inicio();
        int n;
        n = 0;
        while (inicio && n < 10) begin
            n++;
            tick();
        end
        chk("inicio_len", n, IC);
    endtask

    task automatic load(input logic [W-1:0] x, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c,
                        input int maxgap);
        send_word(x, $urandom_range(maxgap, 0));
        send_word(a, $urandom_range(maxgap, 0));
        send_word(b, $urandom_range(maxgap, 0));
        send_word(c, $urandom_range(maxgap, 0));
        check_loaded(x, a, b, c);
        pulso_inicio();
    endtask

    task automatic finish_op(input logic [W-1:0] exp, input int bp,
                             input bit aceita, input bit cedo);
        int n;
        n = 0;
        bus.resultado_aceito = cedo;
        while (!pronto && n < TO + 20) begin
            tick();
            n++;
        end
        bus.resultado_aceito = 1'b0;
        chk("pronto_seen", 32'(pronto), 1);
        chk("erro_run", 32'(erro), 0);
        chk("valid_in_captura", 32'(bus.resultado_valido), 0);
        tick();
        chk("pronto_one_cycle", 32'(pronto), 0);
        chk("res_valid", 32'(bus.resultado_valido), 1);
        chk("res_value", 32'(bus.resultado_out), 32'(exp));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", 32'(bus.resultado_valido), 1);
            chk("bp_value", 32'(bus.resultado_out), 32'(exp));
        end
        if (aceita) begin
            bus.resultado_aceito = 1'b1;
            tick();
            bus.resultado_aceito = 1'b0;
            chk("acc_valid_drop", 32'(bus.resultado_valido), 0);
            chk("acc_dado_pronto", 32'(bus.dado_pronto), 1);
            chk("acc_ocupado", 32'(ocupado), 0);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_X"}, 32'(X), 0);
        chk({tag, "_A"}, 32'(A), 0);
        chk({tag, "_B"}, 32'(B), 0);
        chk({tag, "_C"}, 32'(C), 0);
        chk({tag, "_inicio"}, 32'(inicio), 0);
        chk({tag, "_pronto"}, 32'(pronto), 0);
        chk({tag, "_res"}, 32'(bus.resultado_out), 0);
        chk({tag, "_valid"}, 32'(bus.resultado_valido), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
        chk({tag, "_erro"}, 32'(erro), 0);
        chk({tag, "_dado_pronto"}, 32'(bus.dado_pronto), 1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        check_reset_outs(tag);
        rst = 1'b0;
        tick();
        chk({tag, "_dado_pronto_next"}, 32'(bus.dado_pronto), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit           vp [7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [W-1:0] wp [7] = '{7, 0, 0, 1, 0, 0, 4};
        logic [W-1:0] rx, ra, rb, rc;
        int           nt;
        bit           sticky;

        bus.dado_in          = '0;
        bus.dado_valido      = 1'b0;
        bus.resultado_aceito = 1'b0;

        // Normal run
        rst = 1'b1;
        tick();
        tick();
        check_reset_outs("reset");
        rst = 1'b0;
        led_delay = 10;
        load(3, 2, 1, 5, 0);
        finish_op(16'h001A, 0, 1'b1, 1'b0);

        // Gapped input
        nt = 0;
        for (int i = 0; i < 7; i++) begin
            bus.dado_valido = vp[i];
            bus.dado_in     = wp[i];
            if (vp[i] && bus.dado_pronto) nt++;
            tick();
        end
        bus.dado_valido = 1'b0;
        chk("gap_transfers", nt, 4);
        check_loaded(7, 1, 0, 4);
        pulso_inicio();
        finish_op(poly(7, 1, 0, 4), 20, 1'b1, 1'b1);

        // Second set after backpressure
        led_delay = 5;
        load(16'h0010, 16'h0003, 16'h0007, 16'h1234, 2);
        finish_op(poly(16'h0010, 16'h0003, 16'h0007, 16'h1234),
                  0, 1'b1, 1'b0);

        // Timeout
        auto_core = 1'b0;
        man_led   = 1'b0;
        load(1, 2, 3, 4, 0);
        repeat (TO - 1) tick();
        chk("erro_before_timeout", 32'(erro), 0);
        tick();
        chk("erro_at_timeout", 32'(erro), 1);
        sticky = 1'b1;
        bus.dado_valido = 1'b1;
        for (int i = 0; i < 100; i++) begin
            man_led = (i == 50);
            tick();
            if (!(erro && ocupado && !bus.dado_pronto &&
                  !bus.resultado_valido && !pronto))
                sticky = 1'b0;
        end
        bus.dado_valido = 1'b0;
        man_led = 1'b0;
        chk("erro_sticky", 32'(sticky), 1);
        do_reset("rst_erro");

        // LED in the last ESPERA cycle wins over timeout
        load(9, 8, 7, 6, 0);
        repeat (TO - 1) tick();
        chk("edge_erro_before", 32'(erro), 0);
        man_led = 1'b1;
        man_res = 16'hBEEF;
        tick();
        man_led = 1'b0;
        chk("edge_pronto", 32'(pronto), 1);
        chk("edge_erro", 32'(erro), 0);
        tick();
        chk("edge_valid", 32'(bus.resultado_valido), 1);
        chk("edge_res", 32'(bus.resultado_out), 32'hBEEF);
        bus.resultado_aceito = 1'b1;
        tick();
        bus.resultado_aceito = 1'b0;
        chk("edge_back_carga", 32'(bus.dado_pronto), 1);
        auto_core = 1'b1;

        // Reset during ESPERA: nothing delivered afterwards
        led_delay = 30;
        load(5, 5, 5, 5, 1);
        repeat (5) tick();
        do_reset("rst_espera");
        nt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.resultado_valido || pronto || inicio) nt++;
        end
        chk("no_partial_result", nt, 0);

        // Reset during ENTREGA
        led_delay = 4;
        load(2, 3, 4, 5, 0);
        finish_op(poly(2, 3, 4, 5), 3, 1'b0, 1'b0);
        do_reset("rst_entrega");

        led_delay = 7;
        load(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 0);
        finish_op(poly(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001),
                  1, 1'b1, 1'b0);

        // Random runs
        for (int it = 0; it < 8; it++) begin
            rx = W'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = W'($urandom);
            led_delay = $urandom_range(40, 1);
            load(rx, ra, rb, rc, 3);
            finish_op(poly(rx, ra, rb, rc), $urandom_range(5, 0),
                      1'b1, it[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
